// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, FSM encodings
// and common word/flag values.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WDOG_W    = 16;
  localparam int unsigned RECOVER_W = 4;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [WORD_W-1:0] EXC_ENTRY_DEFAULT = 32'h0000_0020;
  localparam logic [WORD_W-1:0] ZERO_WORD         = 32'h0000_0000;
  localparam logic [WORD_W-1:0] WORD_MAX          = 32'hFFFF_FFFF;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// MEM-stall watchdog: counts consecutive MEM stall cycles and emits a
// one-cycle bus_err pulse on timeout, restarting the count afterwards.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stallreq_mem,
  output logic bus_err
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bus_err <= DISABLE;
    end else begin
      bus_err <= DISABLE;
      if (!stallreq_mem) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        bus_err <= ENABLE;
      end else begin
        cnt <= cnt + WDOG_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline control: stall merging, exception flush/redirect,
// post-flush exception masking, MEM watchdog and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY      = EXC_ENTRY_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err,
  output logic [31:0] stall_cycles
);

  localparam logic [RECOVER_W-1:0] RECOVER_LOAD = RECOVER_W'(RECOVER_CYCLES - 1);

  ctrl_state_e          state, state_next;
  logic [RECOVER_W-1:0] rcnt, rcnt_next;
  logic [STALL_W-1:0]   stall_enc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    unique case (state)
      ST_RUN:     if (except_valid) state_next = ST_FLUSH;
      ST_FLUSH: begin
        rcnt_next  = RECOVER_LOAD;
        state_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (rcnt == '0) state_next = ST_RUN;
        else            rcnt_next  = rcnt - RECOVER_W'(1);
      end
      default:    state_next = ST_RUN;
    endcase
  end

  // MEM has highest priority in the stall encoder
  always_comb begin
    stall_enc = STALL_NONE;
    if (stallreq_mem)     stall_enc = STALL_MEM;
    else if (stallreq_ex) stall_enc = STALL_EX;
    else if (stallreq_id) stall_enc = STALL_ID;
  end

  // Outputs are forced low while reset is held, independent of the clock
  always_comb begin
    stall  = STALL_NONE;
    flush  = DISABLE;
    new_pc = ZERO_WORD;
    if (rst) begin
      unique case (state)
        ST_RUN: begin
          if (except_valid) begin
            flush  = ENABLE;
            new_pc = except_eret ? cp0_epc : EXC_ENTRY;
          end else begin
            stall = stall_enc;
          end
        end
        ST_RECOVER: stall = stall_enc;
        default:    stall = STALL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= ZERO_WORD;
    end else if ((stall != STALL_NONE) && (stall_cycles != WORD_MAX)) begin
      stall_cycles <= stall_cycles + WORD_W'(1);
    end
  end

  stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stallreq_mem(stallreq_mem),
    .bus_err     (bus_err)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog timeout.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid, except_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_err;
  logic [31:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  pipe_ctrl #(
    .EXC_ENTRY     (32'h0000_0020),
    .TIMEOUT_CYCLES(4),
    .RECOVER_CYCLES(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .except_valid(except_valid),
    .except_eret (except_eret),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .bus_err     (bus_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    except_valid = 0; except_eret = 0; cp0_epc = 32'h0;
    #3;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_busErr", 32'(bus_err), 32'h0);
    check("rst_cycles", stall_cycles, 32'h0);
    // inputs active while in reset must not leak to outputs
    except_valid = 1; stallreq_id = 1;
    #1;
    check("rst_gate_flush", 32'(flush), 32'h0);
    check("rst_gate_pc", new_pc, 32'h0);
    check("rst_gate_stall", 32'(stall), 32'h0);
    except_valid = 0; stallreq_id = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // priority encoding
    stallreq_id = 1; #1;
    check("enc_id", 32'(stall), 32'h07);
    tick();
    stallreq_ex = 1; #1;
    check("enc_ex", 32'(stall), 32'h0F);
    tick();
    stallreq_mem = 1; #1;
    check("enc_mem", 32'(stall), 32'h1F);
    tick();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; #1;
    check("cycles_3", stall_cycles, 32'd3);
    check("enc_none", 32'(stall), 32'h0);
    tick();

    // exception redirect
    except_valid = 1; except_eret = 0; #1;
    check("exc_flush", 32'(flush), 32'h1);
    check("exc_pc", new_pc, 32'h20);
    check("exc_stall", 32'(stall), 32'h0);
    tick();
    except_valid = 0; stallreq_id = 1; #1;
    check("flushst_flush", 32'(flush), 32'h0);
    check("flushst_stall", 32'(stall), 32'h0);
    tick();
    stallreq_id = 0; except_valid = 1; except_eret = 1; cp0_epc = 32'h0000_1234; #1;
    check("recover_mask", 32'(flush), 32'h0);
    tick();
    // ERET redirect back in RUN
    #1;
    check("eret_flush", 32'(flush), 32'h1);
    check("eret_pc", new_pc, 32'h1234);
    check("cycles_after_exc", stall_cycles, 32'd3);
    tick();
    except_valid = 0; except_eret = 0;
    tick();
    tick();

    // flush wins over a MEM stall
    stallreq_mem = 1; except_valid = 1; #1;
    check("fos_flush", 32'(flush), 32'h1);
    check("fos_stall", 32'(stall), 32'h0);
    tick();
    stallreq_mem = 0; except_valid = 0;
    tick();
    tick();
    check("fos_cycles", stall_cycles, 32'd3);

    // watchdog: continuous MEM stall, pulse after four counted cycles
    stallreq_mem = 1;
    tick(); check("wd_c1", 32'(bus_err), 32'h0);
    tick(); check("wd_c2", 32'(bus_err), 32'h0);
    tick(); check("wd_c3", 32'(bus_err), 32'h0);
    tick(); check("wd_pulse", 32'(bus_err), 32'h1);
    check("wd_stall_held", 32'(stall), 32'h1F);
    tick(); check("wd_single", 32'(bus_err), 32'h0);
    stallreq_mem = 0;
    tick();
    check("wd_cycles", stall_cycles, 32'd8);
    // short MEM stall never times out
    stallreq_mem = 1;
    tick(); tick();
    stallreq_mem = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wd_nopulse", 32'(bus_err), 32'h0);
    end
    check("cycles_10", stall_cycles, 32'd10);

    // asynchronous reset while in RECOVER
    except_valid = 1; #1;
    tick();
    except_valid = 0;
    tick();
    stallreq_id = 1; #1;
    check("pre_rst_stall", 32'(stall), 32'h07);
    rst = 1'b0; #1;
    check("mid_rst_stall", 32'(stall), 32'h0);
    check("mid_rst_cycles", stall_cycles, 32'h0);
    check("mid_rst_flush", 32'(flush), 32'h0);
    check("mid_rst_busErr", 32'(bus_err), 32'h0);
    stallreq_id = 0;
    @(negedge clk);
    rst = 1'b1;
    except_valid = 1; #1;
    check("post_rst_flush", 32'(flush), 32'h1);
    check("post_rst_pc", new_pc, 32'h20);
    tick();
    except_valid = 0;
    tick();
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
